// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl
// Main sequencer for the multi-cycle LoongArch core. It steps each instruction
// through IF -> ID -> EXE -> MEM -> WB and stalls on the inst/data SRAM ready
// handshakes. It drives the write enables for the IR, PC, register file and
// data SRAM, and it counts retired instructions.
//
// Ports
//   clk          core clock; all state updates on the rising edge
//   reset        synchronous, active-high
//   inst_rdy     inst SRAM data valid for the current inst_req
//   data_rdy     data SRAM access complete for the current data_req
//   dec_br_only  b/beq/bne: no EXE, MEM or WB phase
//   dec_load     ld.w
//   dec_store    st.w
//   dec_gr_we    instruction writes a GPR
//   state        IF=0 ID=1 EXE=2 MEM=3 WB=4 (registered)
//   inst_req     fetch request
//   ir_we        latch inst_sram_rdata into IR
//   pc_we        load nextpc into PC
//   data_req     data SRAM access request
//   data_we      data SRAM write (store)
//   rf_we        regfile write strobe
//   retire       one-cycle pulse per completed instruction
//   inst_cnt     retired-instruction count (registered, wraps)
//   hang         sticky flag: a handshake wait saturated (registered)
module multicycle_ctrl #(
  parameter int CNT_W  = 32,
  parameter int WAIT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inst_rdy,
  input  logic             data_rdy,
  input  logic             dec_br_only,
  input  logic             dec_load,
  input  logic             dec_store,
  input  logic             dec_gr_we,
  output logic [2:0]       state,
  output logic             inst_req,
  output logic             ir_we,
  output logic             pc_we,
  output logic             data_req,
  output logic             data_we,
  output logic             rf_we,
  output logic             retire,
  output logic [CNT_W-1:0] inst_cnt,
  output logic             hang
);

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EXE = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4
  } state_t;

  localparam logic [WAIT_W-1:0] WAIT_SAT = {WAIT_W{1'b1}};
  localparam logic [WAIT_W-1:0] WAIT_ONE = {{(WAIT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t            state_r;
  state_t            state_nxt_s;
  logic [WAIT_W-1:0] wait_cnt_r;
  logic [WAIT_W-1:0] wait_nxt_s;
  logic [CNT_W-1:0]  inst_cnt_r;
  logic              hang_r;

  logic inst_req_s;
  logic ir_we_s;
  logic pc_we_s;
  logic data_req_s;
  logic data_we_s;
  logic rf_we_s;
  logic retire_s;

  // Next-state and raw strobe decode from the current phase and handshakes.
  always_comb begin
    state_nxt_s = S_IF;
    inst_req_s  = 1'b0;
    ir_we_s     = 1'b0;
    pc_we_s     = 1'b0;
    data_req_s  = 1'b0;
    data_we_s   = 1'b0;
    rf_we_s     = 1'b0;
    retire_s    = 1'b0;
    case (state_r)
      S_IF: begin
        inst_req_s = 1'b1;
        if (inst_rdy) begin
          ir_we_s     = 1'b1;
          state_nxt_s = S_ID;
        end else begin
          state_nxt_s = S_IF;
        end
      end
      S_ID: begin
        // Branches finish here: the PC update is their only side effect.
        if (dec_br_only) begin
          pc_we_s     = 1'b1;
          retire_s    = 1'b1;
          state_nxt_s = S_IF;
        end else begin
          state_nxt_s = S_EXE;
        end
      end
      S_EXE: begin
        if (dec_load || dec_store) begin
          state_nxt_s = S_MEM;
        end else begin
          state_nxt_s = S_WB;
        end
      end
      S_MEM: begin
        data_req_s = 1'b1;
        // load+store together behaves as a load, so no write is issued.
        data_we_s  = dec_store & ~dec_load;
        if (data_rdy) begin
          if (dec_load) begin
            state_nxt_s = S_WB;
          end else begin
            pc_we_s     = 1'b1;
            retire_s    = 1'b1;
            state_nxt_s = S_IF;
          end
        end else begin
          state_nxt_s = S_MEM;
        end
      end
      S_WB: begin
        rf_we_s     = dec_gr_we;
        pc_we_s     = 1'b1;
        retire_s    = 1'b1;
        state_nxt_s = S_IF;
      end
      default: begin
        state_nxt_s = S_IF;
      end
    endcase
  end

  // Handshake wait counter: only IF/MEM can hold their state, so any
  // non-changing cycle is a wait cycle; it saturates rather than wraps.
  always_comb begin
    wait_nxt_s = {WAIT_W{1'b0}};
    if (state_nxt_s != state_r) begin
      wait_nxt_s = {WAIT_W{1'b0}};
    end else if (wait_cnt_r == WAIT_SAT) begin
      wait_nxt_s = wait_cnt_r;
    end else begin
      wait_nxt_s = wait_cnt_r + WAIT_ONE;
    end
  end

  // Sequencer state, wait counter, retire counter and sticky hang flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= S_IF;
      wait_cnt_r <= {WAIT_W{1'b0}};
      inst_cnt_r <= {CNT_W{1'b0}};
      hang_r     <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      wait_cnt_r <= wait_nxt_s;
      if (retire_s) begin
        inst_cnt_r <= inst_cnt_r + CNT_ONE;
      end else begin
        inst_cnt_r <= inst_cnt_r;
      end
      // Raised on the same edge the counter saturates; the wait itself goes on.
      hang_r <= hang_r | (wait_nxt_s == WAIT_SAT);
    end
  end

  assign state    = state_r;
  assign inst_cnt = inst_cnt_r;
  assign hang     = hang_r;

  // Strobes are suppressed during reset so an interrupted instruction
  // leaves no architectural side effect.
  assign inst_req = inst_req_s & ~reset;
  assign ir_we    = ir_we_s    & ~reset;
  assign pc_we    = pc_we_s    & ~reset;
  assign data_req = data_req_s & ~reset;
  assign data_we  = data_we_s  & ~reset;
  assign rf_we    = rf_we_s    & ~reset;
  assign retire   = retire_s   & ~reset;

endmodule

// File: tb/tb_multicycle_ctrl.sv
module tb_multicycle_ctrl;

  localparam int CNT_W  = 4;
  localparam int WAIT_W = 4;
  localparam int SAT    = (1 << WAIT_W) - 1;

  logic             clk;
  logic             reset;
  logic             inst_rdy;
  logic             data_rdy;
  logic             dec_br_only;
  logic             dec_load;
  logic             dec_store;
  logic             dec_gr_we;
  logic [2:0]       state;
  logic             inst_req;
  logic             ir_we;
  logic             pc_we;
  logic             data_req;
  logic             data_we;
  logic             rf_we;
  logic             retire;
  logic [CNT_W-1:0] inst_cnt;
  logic             hang;

  multicycle_ctrl #(.CNT_W(CNT_W), .WAIT_W(WAIT_W)) dut (
    .clk(clk), .reset(reset), .inst_rdy(inst_rdy), .data_rdy(data_rdy),
    .dec_br_only(dec_br_only), .dec_load(dec_load), .dec_store(dec_store),
    .dec_gr_we(dec_gr_we), .state(state), .inst_req(inst_req), .ir_we(ir_we),
    .pc_we(pc_we), .data_req(data_req), .data_we(data_we), .rf_we(rf_we),
    .retire(retire), .inst_cnt(inst_cnt), .hang(hang)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // model state: retire count, hang flag, current consecutive-wait run
  logic [CNT_W-1:0] m_cnt;
  logic             m_hang;
  int               m_run;
  int               cyc;

  // expectations for the current cycle; strobe order {ireq,irwe,pcwe,dreq,dwe,rfwe}
  logic [2:0]       e_state;
  logic [5:0]       e_strb;
  logic [CNT_W-1:0] e_cnt;
  logic             e_hang;
  logic             chk_en;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, req);
  endtask

  // per-cycle compare against the model's expectation
  always @(negedge clk) begin
    if (chk_en) begin
      chk("state",    32'(state),    32'(e_state));
      chk("inst_req", 32'(inst_req), 32'(e_strb[5]));
      chk("ir_we",    32'(ir_we),    32'(e_strb[4]));
      chk("pc_we",    32'(pc_we),    32'(e_strb[3]));
      chk("retire",   32'(retire),   32'(e_strb[3]));
      chk("data_req", 32'(data_req), 32'(e_strb[2]));
      chk("data_we",  32'(data_we),  32'(e_strb[1]));
      chk("rf_we",    32'(rf_we),    32'(e_strb[0]));
      chk("inst_cnt", 32'(inst_cnt), 32'(e_cnt));
      chk("hang",     32'(hang),     32'(e_hang));
    end
  end

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  // One clock cycle: drive inputs, publish expectations, then advance the model.
  task automatic step(input logic rst, input logic [2:0] st, input logic irdy,
                      input logic drdy, input logic [3:0] dec, input logic [5:0] strb,
                      input logic waiting);
    reset    = rst;
    inst_rdy = irdy;
    data_rdy = drdy;
    {dec_br_only, dec_load, dec_store, dec_gr_we} = dec;
    e_state = st;
    e_strb  = rst ? 6'b000000 : strb;
    e_cnt   = m_cnt;
    e_hang  = m_hang;
    chk_en  = 1'b1;
    @(posedge clk);
    #1;
    cyc++;
    if (rst) begin
      m_cnt  = '0;
      m_hang = 1'b0;
      m_run  = 0;
    end else begin
      if (strb[3]) m_cnt = m_cnt + 1'b1;
      if (waiting) begin
        m_run++;
        if (m_run >= SAT) m_hang = 1'b1;
      end else begin
        m_run = 0;
      end
    end
  endtask

  // kind: 0 branch, 1 ALU, 2 load, 3 store, 4 load+store (acts as load)
  task automatic run_instr(input int kind, input logic gwe, input int if_wait,
                           input int mem_wait, input bit abort);
    logic br, ld, sto, is_st, mem;
    logic [3:0] dec;
    br  = (kind == 0);
    ld  = (kind == 2) || (kind == 4);
    sto = (kind == 3) || (kind == 4);
    if (br) begin
      ld  = rb();   // branch wins over any memory flag
      sto = rb();
    end
    dec   = {br, ld, sto, gwe};
    is_st = !br && sto && !ld;
    mem   = !br && (ld || sto);
    for (int i = 0; i < if_wait; i++)
      step(1'b0, 3'd0, 1'b0, rb(), 4'($urandom), 6'b100000, 1'b1);
    step(1'b0, 3'd0, 1'b1, rb(), 4'($urandom), 6'b110000, 1'b0);
    step(1'b0, 3'd1, rb(), rb(), dec, br ? 6'b001000 : 6'b000000, 1'b0);
    if (!br) begin
      step(1'b0, 3'd2, rb(), rb(), dec, 6'b000000, 1'b0);
      if (mem) begin
        for (int i = 0; i < mem_wait; i++)
          step(1'b0, 3'd3, rb(), 1'b0, dec, {3'b000, 1'b1, is_st, 1'b0}, 1'b1);
        if (abort)
          step(1'b1, 3'd3, rb(), 1'b1, dec, 6'b000000, 1'b0);
        else
          step(1'b0, 3'd3, rb(), 1'b1, dec, {2'b00, is_st, 1'b1, is_st, 1'b0}, 1'b0);
      end
      if (!is_st && !(mem && abort))
        step(1'b0, 3'd4, rb(), rb(), dec, {3'b001, 2'b00, gwe}, 1'b0);
    end
  endtask

  int c0;

  initial begin
    reset = 1'b1; inst_rdy = 1'b0; data_rdy = 1'b0;
    dec_br_only = 1'b0; dec_load = 1'b0; dec_store = 1'b0; dec_gr_we = 1'b0;
    chk_en = 1'b0; m_cnt = '0; m_hang = 1'b0; m_run = 0; cyc = 0;
    e_state = 3'd0; e_strb = 6'b000000; e_cnt = '0; e_hang = 1'b0;
    @(posedge clk);
    #1;

    // reset 3 cycles, then add.w
    for (int i = 0; i < 3; i++) step(1'b1, 3'd0, 1'b1, 1'b1, 4'b0001, 6'b000000, 1'b0);
    c0 = cyc;
    run_instr(1, 1'b1, 0, 0, 1'b0);
    chk("alu_cycles", 32'(cyc - c0), 32'd4);
    chk("add_cnt", 32'(inst_cnt), 32'd1);
    chk("model_cnt_add", 32'(m_cnt), 32'd1);

    // ld.w with 3 data wait cycles
    c0 = cyc;
    run_instr(2, 1'b1, 0, 3, 1'b0);
    chk("load_cycles", 32'(cyc - c0), 32'd8);
    chk("load_cnt", 32'(inst_cnt), 32'd2);

    // st.w, immediate ready
    c0 = cyc;
    run_instr(3, 1'b1, 0, 0, 1'b0);
    chk("store_cycles", 32'(cyc - c0), 32'd4);
    chk("store_cnt", 32'(inst_cnt), 32'd3);

    // 10 branches back to back, then wrap the 4-bit counter
    step(1'b1, 3'd0, 1'b0, 1'b0, 4'b0000, 6'b000000, 1'b0);
    c0 = cyc;
    for (int i = 0; i < 10; i++) run_instr(0, rb(), 0, 0, 1'b0);
    chk("branch_cycles", 32'(cyc - c0), 32'd20);
    chk("branch_cnt", 32'(inst_cnt), 32'd10);
    for (int i = 0; i < 5; i++) run_instr(0, rb(), 0, 0, 1'b0);
    chk("cnt_15", 32'(inst_cnt), 32'd15);
    chk("model_cnt_15", 32'(m_cnt), 32'd15);
    run_instr(0, 1'b0, 0, 0, 1'b0);
    chk("cnt_wrap", 32'(inst_cnt), 32'd0);

    // hang: 14 waits do not set it, 15 do; it survives until reset
    step(1'b1, 3'd0, 1'b0, 1'b0, 4'b0000, 6'b000000, 1'b0);
    run_instr(1, 1'b0, SAT - 1, 0, 1'b0);
    chk("hang_14", 32'(hang), 32'd0);
    run_instr(1, 1'b0, SAT, 0, 1'b0);
    chk("hang_15", 32'(hang), 32'd1);
    chk("model_hang_15", 32'(m_hang), 32'd1);
    run_instr(3, 1'b0, 0, 0, 1'b0);
    chk("hang_sticky", 32'(hang), 32'd1);
    step(1'b1, 3'd0, 1'b0, 1'b0, 4'b0000, 6'b000000, 1'b0);
    chk("hang_cleared", 32'(hang), 32'd0);

    // reset during MEM of ld.w discards it
    run_instr(1, 1'b1, 0, 0, 1'b0);
    run_instr(2, 1'b1, 0, 2, 1'b1);
    chk("abort_state", 32'(state), 32'd0);
    chk("abort_cnt", 32'(inst_cnt), 32'd0);

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      int k, iw, mw;
      bit ab;
      k  = int'($urandom_range(0, 4));
      iw = ($urandom_range(0, 19) == 0) ? int'($urandom_range(10, 20)) : int'($urandom_range(0, 2));
      mw = ($urandom_range(0, 19) == 0) ? int'($urandom_range(10, 20)) : int'($urandom_range(0, 3));
      ab = ($urandom_range(0, 29) == 0);
      run_instr(k, rb(), iw, mw, ab);
      if ($urandom_range(0, 39) == 0)
        step(1'b1, 3'd0, rb(), rb(), 4'($urandom), 6'b000000, 1'b0);
    end

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
